// File: rtl/seed_link_rx.sv
// seed_link_rx: decodes the remote board's seed packet from the UART byte
// stream and hands a validated seed_x/seed_y pair plus a one-cycle
// remote_start strobe to the point generator and the mode controller.
// Packet: HEADER, X, Y [, CHK = HEADER ^ X ^ Y].
// Build option: define SEED_RX_CHECKSUM_EN for the 4-byte packet with the
// trailing checksum; leave it undefined for the 3-byte packet.

package snake_pkg;
  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    OVER = 2'd2
  } game_mode;
endpackage

module seed_link_rx
  import snake_pkg::*;
#(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 75000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk_75,
  input  logic             rst,
  input  game_mode         mode,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [4:0]       seed_x_out,
  output logic [4:0]       seed_y_out,
  output logic             remote_start,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_X   = 2'd1,
    GET_Y   = 2'd2,
    GET_CHK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [4:0]       x_q, x_d;
`ifdef SEED_RX_CHECKSUM_EN
  logic [4:0]       y_q, y_d;
`endif
  logic [4:0]       seed_x_q, seed_x_d;
  logic [4:0]       seed_y_q, seed_y_d;
  logic             start_q, start_d;
  logic             busy_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_inc;

  logic             is_hdr;
  logic             hi_zero;

  assign is_hdr  = (rx_data == HEADER);
  assign hi_zero = (rx_data[7:5] == 3'b000);

  // Packet decoder: mode abort has priority, then a received byte, then timeout.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
`ifdef SEED_RX_CHECKSUM_EN
    y_d      = y_q;
`endif
    seed_x_d = seed_x_q;
    seed_y_d = seed_y_q;
    start_d  = 1'b0;
    err_inc  = 1'b0;

    if (mode != MENU) begin
      // Leaving the menu silently drops any partial packet.
      state_d = IDLE;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (is_hdr) state_d = GET_X;
        end
        GET_X: begin
          if (is_hdr) begin
            err_inc = 1'b1;            // resync: remain waiting for X
          end else if (!hi_zero || rx_data[4:0] > 5'd30) begin
            state_d = IDLE;
            err_inc = 1'b1;
          end else begin
            x_d     = rx_data[4:0];
            state_d = GET_Y;
          end
        end
        GET_Y: begin
          if (is_hdr) begin
            state_d = GET_X;
            err_inc = 1'b1;
          end else if (!hi_zero || rx_data[4:0] > 5'd23) begin
            state_d = IDLE;
            err_inc = 1'b1;
          end else begin
`ifdef SEED_RX_CHECKSUM_EN
            y_d      = rx_data[4:0];
            state_d  = GET_CHK;
`else
            seed_x_d = x_q;
            seed_y_d = rx_data[4:0];
            start_d  = 1'b1;
            state_d  = IDLE;
`endif
          end
        end
`ifdef SEED_RX_CHECKSUM_EN
        GET_CHK: begin
          // A header byte here is just a (probably wrong) checksum value.
          state_d = IDLE;
          if (rx_data == (HEADER ^ {3'b000, x_q} ^ {3'b000, y_q})) begin
            seed_x_d = x_q;
            seed_y_d = y_q;
            start_d  = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_inc = 1'b1;
    end
  end

  // Inter-byte timer: runs only mid-packet, restarts on every byte.
  always_comb begin
    if (mode != MENU || rx_valid || state_q == IDLE || tmo_q == TMO_LAST) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Saturating rejected-packet counter.
  always_comb begin
    err_d = err_q;
    if (err_inc && err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
  end

  // Control and visible outputs, synchronously reset.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      seed_x_q <= 5'd1;
      seed_y_q <= 5'd23;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      seed_x_q <= seed_x_d;
      seed_y_q <= seed_y_d;
      start_q  <= start_d;
      busy_q   <= (state_d != IDLE);
      err_q    <= err_d;
    end
  end

  // Partial-packet holding registers; never visible until accepted.
  always_ff @(posedge clk_75) begin
    x_q <= x_d;
`ifdef SEED_RX_CHECKSUM_EN
    y_q <= y_d;
`endif
  end

  assign seed_x_out   = seed_x_q;
  assign seed_y_out   = seed_y_q;
  assign remote_start = start_q;
  assign busy         = busy_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_seed_link_rx.sv
// Scoreboard bench for seed_link_rx: stimulus pushes expected acceptances,
// a negedge monitor pops them whenever remote_start is seen.
module tb_seed_link_rx;

  logic                 clk_75;
  logic                 rst;
  snake_pkg::game_mode  mode;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [4:0]           seed_x_out;
  logic [4:0]           seed_y_out;
  logic                 remote_start;
  logic                 busy;
  logic [7:0]           err_cnt;

  seed_link_rx #(
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(16),
    .ERR_W(8)
  ) dut (
    .clk_75(clk_75),
    .rst(rst),
    .mode(mode),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .seed_x_out(seed_x_out),
    .seed_y_out(seed_y_out),
    .remote_start(remote_start),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  typedef struct {
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   k;
  logic start_prev = 1'b0;

  initial clk_75 = 1'b0;
  always #5 clk_75 = ~clk_75;

  always @(posedge clk_75) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every remote_start must match the oldest expected acceptance.
  always @(negedge clk_75) begin
    if (remote_start) begin
      chk("start_single_cycle", int'(start_prev), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_start", int'(remote_start), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("seed_x", int'(seed_x_out), e.x);
        chk("seed_y", int'(seed_y_out), e.y);
        chk("start_cycle", cyc, e.cyc);
      end
    end
    start_prev = remote_start;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_75);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic expect_accept(input int x, input int y);
    exp_q.push_back('{x: x, y: y, cyc: cyc + 1});
  endtask

  // Full well-formed packet that must be accepted.
  task automatic send_pkt_ok(input logic [4:0] x, input logic [4:0] y);
    logic [7:0] bx, by;
    bx = {3'b000, x};
    by = {3'b000, y};
    send_byte(8'hA5);
    send_byte(bx);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(by);
    expect_accept(int'(x), int'(y));
    send_byte(8'hA5 ^ bx ^ by);
`else
    expect_accept(int'(x), int'(y));
    send_byte(by);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_75);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    mode     = snake_pkg::MENU;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk_75);

    // Reset state
    chk("rst_seed_x", int'(seed_x_out), 1);
    chk("rst_seed_y", int'(seed_y_out), 23);
    chk("rst_start", int'(remote_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_cnt), 0);
    rst = 1'b0;

    // Good packet 7/12
    send_byte(8'hA5);
    chk("busy_after_hdr", int'(busy), 1);
    send_byte(8'h07);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(8'h0C);
    expect_accept(7, 12);
    send_byte(8'hAE);
`else
    expect_accept(7, 12);
    send_byte(8'h0C);
`endif
    chk("good_err", int'(err_cnt), 0);
    chk("good_busy", int'(busy), 0);
    @(negedge clk_75);
    chk("good_seed_hold_x", int'(seed_x_out), 7);
    chk("good_start_low", int'(remote_start), 0);

    // Rejected packet: bad checksum (or out-of-range y without checksum)
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h07);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(8'h0C);
    send_byte(8'h00);
`else
    send_byte(8'h19);
`endif
    repeat (2) @(negedge clk_75);
    chk("bad_err", int'(err_cnt), 1);
    chk("bad_seed_x", int'(seed_x_out), 1);
    chk("bad_seed_y", int'(seed_y_out), 23);
    chk("bad_busy", int'(busy), 0);

    // x out of range, then header in the Y slot resyncs
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h1F);
    chk("xrange_err", int'(err_cnt), 1);
    chk("xrange_busy", int'(busy), 0);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'hA5);
    chk("yhdr_err", int'(err_cnt), 2);
    chk("yhdr_busy", int'(busy), 1);
    send_byte(8'h04);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(8'h05);
    expect_accept(4, 5);
    send_byte(8'hA4);
`else
    expect_accept(4, 5);
    send_byte(8'h05);
`endif
    chk("resync_err", int'(err_cnt), 2);

    // Header in the X slot stays waiting for X
    do_reset();
    send_byte(8'hA5);
    send_byte(8'hA5);
    chk("xhdr_err", int'(err_cnt), 1);
    chk("xhdr_busy", int'(busy), 1);
    send_byte(8'h06);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(8'h07);
    expect_accept(6, 7);
    send_byte(8'hA4);
`else
    expect_accept(6, 7);
    send_byte(8'h07);
`endif

    // Inter-byte timeout after 16 idle cycles
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk_75);
      k++;
    end
    chk("tmo_cycles", k, 16);
    chk("tmo_err", int'(err_cnt), 1);
    send_pkt_ok(5'd3, 5'd4);
    chk("tmo_after_err", int'(err_cnt), 1);

    // Mode leaves MENU before the final byte: packet discarded, no error
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
`ifdef SEED_RX_CHECKSUM_EN
    send_byte(8'h03);
    mode = snake_pkg::GAME;
    send_byte(8'hA4);
`else
    mode = snake_pkg::GAME;
    send_byte(8'h03);
`endif
    repeat (2) @(negedge clk_75);
    chk("mode_err", int'(err_cnt), 0);
    chk("mode_busy", int'(busy), 0);
    chk("mode_seed_x", int'(seed_x_out), 1);
    chk("mode_seed_y", int'(seed_y_out), 23);
    send_byte(8'hA5);
    chk("mode_ignore_busy", int'(busy), 0);
    mode = snake_pkg::MENU;
    @(negedge clk_75);
    send_pkt_ok(5'd2, 5'd3);

    // Reset mid-packet returns to idle; the tail bytes are dropped
    send_byte(8'hA5);
    send_byte(8'h07);
    rst = 1'b1;
    @(negedge clk_75);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_seed_x", int'(seed_x_out), 1);
    send_byte(8'h0C);
    send_byte(8'hAE);
    repeat (2) @(negedge clk_75);
    chk("midrst_err", int'(err_cnt), 0);
    chk("midrst_seed_y", int'(seed_y_out), 23);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hA5);
      send_byte(8'h1F);
    end
    chk("sat_256", int'(err_cnt), 255);
    send_byte(8'hA5);
    send_byte(8'h1F);
    chk("sat_257", int'(err_cnt), 255);

    // Accept 9/10 after saturation
    send_pkt_ok(5'd9, 5'd10);
    repeat (3) @(negedge clk_75);
    chk("final_seed_x", int'(seed_x_out), 9);
    chk("final_seed_y", int'(seed_y_out), 10);
    chk("pending_expect", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
